// File: rtl/slurm16_cpu_instruction_prefetch.sv
// Instruction prefetch: in-order word reads into a small {addr, data} FIFO
// feeding the pipeline; a PC load flushes it and drops stale responses.
module slurm16_cpu_instruction_prefetch #(
    parameter int          DEPTH      = 4,
    parameter logic [14:0] RESET_ADDR = 15'h0000
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic        load_pc_request,
    input  logic [14:0] load_pc_address,
    output logic        mem_request,
    output logic [14:0] mem_address,
    input  logic        mem_grant,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_data,
    output logic        instruction_valid,
    output logic [15:0] instruction_in,
    output logic [14:0] instruction_address_in,
    input  logic        instruction_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 2;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t LIM = cnt_t'(DEPTH);

    logic [14:0] r_fetch_pc;
    logic [14:0] r_fifo_addr [DEPTH];
    logic [15:0] r_fifo_data [DEPTH];
    logic [14:0] r_aq        [DEPTH];
    ptr_t        r_f_rd;
    ptr_t        r_f_wr;
    ptr_t        r_q_rd;
    ptr_t        r_q_wr;
    cnt_t        r_count;
    cnt_t        r_live;
    cnt_t        r_discard;

    logic w_issue;
    logic w_drop;
    logic w_accept;
    logic w_resp;
    logic w_push;
    logic w_pop;
    logic w_room;

    // Reserve FIFO space for every live read so responses never overflow it
    assign w_room = ((r_count + r_live) < LIM) &&
                    ((r_live + r_discard) < LIM);

    assign mem_request = RSTb & ~load_pc_request & w_room;
    assign mem_address = r_fetch_pc;

    assign w_issue  = mem_request & mem_grant;
    assign w_drop   = mem_data_valid & (r_discard != '0);
    assign w_accept = mem_data_valid & (r_discard == '0) & (r_live != '0);
    assign w_resp   = w_drop | w_accept;
    assign w_push   = w_accept & ~load_pc_request;

    assign instruction_valid = (r_count != '0);
    assign w_pop = instruction_valid & instruction_ready;

    assign instruction_in = instruction_valid ?
                            r_fifo_data[r_f_rd] : 16'h0000;
    assign instruction_address_in = instruction_valid ?
                                    r_fifo_addr[r_f_rd] : 15'h0000;

    always_ff @(posedge CLK) begin
        if (RSTb && w_push) begin
            r_fifo_addr[r_f_wr] <= r_aq[r_q_rd];
            r_fifo_data[r_f_wr] <= mem_data;
        end
        if (w_issue) begin
            r_aq[r_q_wr] <= r_fetch_pc;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            r_fetch_pc <= RESET_ADDR;
            r_f_rd     <= '0;
            r_f_wr     <= '0;
            r_q_rd     <= '0;
            r_q_wr     <= '0;
            r_count    <= '0;
            r_live     <= '0;
            r_discard  <= '0;
        end else if (load_pc_request) begin
            // Everything still outstanding becomes stale
            r_fetch_pc <= load_pc_address;
            r_f_rd     <= '0;
            r_f_wr     <= '0;
            r_q_rd     <= '0;
            r_q_wr     <= '0;
            r_count    <= '0;
            r_live     <= '0;
            r_discard  <= r_discard + r_live - cnt_t'(w_resp);
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 15'd1;
                r_q_wr     <= r_q_wr + ptr_t'(1);
            end
            if (w_accept) begin
                r_q_rd <= r_q_rd + ptr_t'(1);
                r_f_wr <= r_f_wr + ptr_t'(1);
            end
            if (w_pop) begin
                r_f_rd <= r_f_rd + ptr_t'(1);
            end
            r_count   <= r_count + cnt_t'(w_push) - cnt_t'(w_pop);
            r_live    <= r_live + cnt_t'(w_issue) - cnt_t'(w_accept);
            r_discard <= r_discard - cnt_t'(w_drop);
        end
    end

endmodule

// File: tb/tb_slurm16_cpu_instruction_prefetch.sv
// Bench for the instruction prefetch unit: per-cycle vector table plus
// hand-written flush, stall and wrap sequences against a latency-L memory.
module tb_slurm16_cpu_instruction_prefetch;

    logic        CLK = 1'b0;
    logic        RSTb = 1'b0;
    logic        load_pc_request = 1'b0;
    logic [14:0] load_pc_address = 15'h0;
    logic        mem_request;
    logic [14:0] mem_address;
    logic        mem_grant = 1'b1;
    logic        mem_data_valid;
    logic [15:0] mem_data;
    logic        instruction_valid;
    logic [15:0] instruction_in;
    logic [14:0] instruction_address_in;
    logic        instruction_ready = 1'b0;

    int tests = 0;
    int fails = 0;
    int lat   = 1;

    logic [7:0]  sv;
    logic [14:0] sa [8];

    always #5 CLK = ~CLK;

    slurm16_cpu_instruction_prefetch #(
        .DEPTH(4),
        .RESET_ADDR(15'h0000)
    ) dut (
        .CLK(CLK),
        .RSTb(RSTb),
        .load_pc_request(load_pc_request),
        .load_pc_address(load_pc_address),
        .mem_request(mem_request),
        .mem_address(mem_address),
        .mem_grant(mem_grant),
        .mem_data_valid(mem_data_valid),
        .mem_data(mem_data),
        .instruction_valid(instruction_valid),
        .instruction_in(instruction_in),
        .instruction_address_in(instruction_address_in),
        .instruction_ready(instruction_ready)
    );

    // Memory: fixed latency pipeline, memory[a] = 16'h1000 + a
    always @(posedge CLK) begin
        if (!RSTb) begin
            sv <= '0;
        end else begin
            sv    <= {sv[6:0], mem_request & mem_grant};
            sa[0] <= mem_address;
            for (int k = 1; k < 8; k++) sa[k] <= sa[k-1];
        end
    end

    assign mem_data_valid = sv[lat-1];
    assign mem_data = 16'h1000 + {1'b0, sa[lat-1]};

    typedef struct {
        logic        rdy;
        logic        req;
        logic [14:0] maddr;
        logic        vld;
        logic [14:0] iaddr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic q,
                                input int ma, input logic v,
                                input int ia);
        vec_t x;
        x.rdy   = r;
        x.req   = q;
        x.maddr = 15'(ma);
        x.vld   = v;
        x.iaddr = 15'(ia);
        tbl.push_back(x);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h",
                     name, $time, act, exp);
        end
    endtask

    task automatic do_reset(input int l);
        @(negedge CLK);
        RSTb = 1'b0;
        load_pc_request = 1'b0;
        mem_grant = 1'b1;
        instruction_ready = 1'b0;
        lat = l;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_req", 32'(mem_request), 32'h0);
        chk("rst_valid", 32'(instruction_valid), 32'h0);
        chk("rst_data", 32'(instruction_in), 32'h0);
        chk("rst_addr", 32'(instruction_address_in), 32'h0);
        RSTb = 1'b1;
    endtask

    task automatic expect_stream(input logic [14:0] start, input int n,
                                 input int budget, input string tag);
        logic [14:0] e;
        int got;
        int cyc;
        e = start;
        got = 0;
        cyc = 0;
        while (got < n && cyc < budget) begin
            if (instruction_valid && instruction_ready) begin
                chk({tag, "_addr"}, 32'(instruction_address_in), 32'(e));
                chk({tag, "_data"}, 32'(instruction_in),
                    32'h1000 + 32'(e));
                e++;
                got++;
            end
            @(negedge CLK);
            #1;
            cyc++;
        end
        tests++;
        if (got < n) begin
            fails++;
            $display("FAIL %s_timeout: got %0d words expected %0d",
                     tag, got, n);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [14:0] e;

        for (int c = 0; c < 2; c++)   add(1, 1, c, 0, 0);
        for (int c = 2; c < 6; c++)   add(1, 1, c, 1, c - 2);
        for (int c = 6; c < 8; c++)   add(0, 1, c, 1, 4);
        for (int c = 8; c < 16; c++)  add(0, 0, 0, 1, 4);
        add(1, 0, 0, 1, 4);
        for (int c = 17; c < 22; c++) add(1, 1, c - 9, 1, c - 12);

        // Free run, priming latency, backpressure to full and release
        do_reset(1);
        foreach (tbl[i]) begin
            instruction_ready = tbl[i].rdy;
            #1;
            chk("tbl_req", 32'(mem_request), 32'(tbl[i].req));
            if (tbl[i].req)
                chk("tbl_maddr", 32'(mem_address), 32'(tbl[i].maddr));
            chk("tbl_valid", 32'(instruction_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) begin
                chk("tbl_iaddr", 32'(instruction_address_in),
                    32'(tbl[i].iaddr));
                chk("tbl_data", 32'(instruction_in),
                    32'h1000 + 32'(tbl[i].iaddr));
            end
            @(negedge CLK);
        end

        // Flush with three reads in flight, latency 3
        do_reset(3);
        instruction_ready = 1'b1;
        repeat (3) @(negedge CLK);
        load_pc_request = 1'b1;
        load_pc_address = 15'h0040;
        #1;
        chk("fl3_req", 32'(mem_request), 32'h0);
        @(negedge CLK);
        load_pc_request = 1'b0;
        #1;
        chk("fl3_req_next", 32'(mem_request), 32'h1);
        chk("fl3_maddr", 32'(mem_address), 32'h0040);
        expect_stream(15'h0040, 4, 30, "fl3");

        // Flush coincident with a pop and an arriving response
        do_reset(1);
        instruction_ready = 1'b1;
        repeat (4) @(negedge CLK);
        #1;
        chk("co_pre_valid", 32'(instruction_valid), 32'h1);
        load_pc_request = 1'b1;
        load_pc_address = 15'h0020;
        @(negedge CLK);
        load_pc_request = 1'b0;
        #1;
        chk("co_empty", 32'(instruction_valid), 32'h0);
        chk("co_req", 32'(mem_request), 32'h1);
        chk("co_maddr", 32'(mem_address), 32'h0020);
        expect_stream(15'h0020, 3, 20, "co");

        // Back-to-back flushes, last one wins, then address wrap
        @(negedge CLK);
        load_pc_request = 1'b1;
        load_pc_address = 15'h0030;
        #1;
        chk("bb_req0", 32'(mem_request), 32'h0);
        @(negedge CLK);
        load_pc_address = 15'h7FFE;
        #1;
        chk("bb_req1", 32'(mem_request), 32'h0);
        @(negedge CLK);
        load_pc_request = 1'b0;
        #1;
        chk("bb_maddr", 32'(mem_address), 32'h7FFE);
        expect_stream(15'h7FFE, 4, 20, "wrap");

        // Grant stall mid-stream: address holds, output stays contiguous
        do_reset(1);
        instruction_ready = 1'b1;
        repeat (6) @(negedge CLK);
        mem_grant = 1'b0;
        #1;
        e = 15'd4;
        for (int i = 0; i < 5; i++) begin
            chk("st_req", 32'(mem_request), 32'h1);
            chk("st_maddr", 32'(mem_address), 32'h6);
            if (instruction_valid) begin
                chk("st_iaddr", 32'(instruction_address_in), 32'(e));
                e++;
            end
            @(negedge CLK);
            #1;
        end
        mem_grant = 1'b1;
        expect_stream(e, 5, 20, "st");

        // Reset mid-operation drops everything
        do_reset(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
